// File: rtl/fetch_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID latch.
package fetch_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]    PC_INCR = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] NOP_ENC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_latch.sv
// IF/ID pipeline register: flush beats load; with neither it holds its contents.
module fetch_latch
  import fetch_pkg::*;
#(
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   valid_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= '0;
      valid_out       <= 1'b0;
    end else if (flush) begin
      instruction_out <= NOP_INSTR;
      pc_out          <= '0;
      valid_out       <= 1'b0;
    end else if (load) begin
      instruction_out <= load_instr;
      pc_out          <= load_pc;
      valid_out       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, redirects, decode stall.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic [PC_WIDTH-1:0]    br_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   valid_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count,
`endif
  output fetch_state_e           dbg_state
);

  // Handshake: imem_req with imem_addr stays asserted and stable until a cycle
  // with imem_valid=1, which completes it; at most one request is outstanding.

  fetch_state_e           state, state_n;
  logic [PC_WIDTH-1:0]    pc_reg, pc_n;
  logic [PC_WIDTH-1:0]    req_addr, req_n;
  logic                   kill, kill_n;
  logic [INSTR_WIDTH-1:0] hold_instr, hold_instr_n;
  logic [PC_WIDTH-1:0]    hold_pc, hold_pc_n;
  logic                   lat_load, lat_flush, fetch_hit;
  logic [INSTR_WIDTH-1:0] lat_instr;
  logic [PC_WIDTH-1:0]    lat_pc;
  logic [PC_WIDTH-1:0]    req_inc, br_tgt;

  assign req_inc   = req_addr + PC_INCR;
  assign br_tgt    = word_align(br_target);
  assign imem_req  = (state == WAIT);
  assign imem_addr = req_addr;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ISSUE;
      pc_reg     <= RESET_PC;
      req_addr   <= RESET_PC;
      kill       <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else begin
      state      <= state_n;
      pc_reg     <= pc_n;
      req_addr   <= req_n;
      kill       <= kill_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc_reg;
    req_n        = req_addr;
    kill_n       = kill;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    lat_load     = 1'b0;
    lat_instr    = imem_rdata;
    lat_pc       = req_inc;
    fetch_hit    = 1'b0;
    unique case (state)
      ISSUE: begin
        pc_n    = br_taken ? br_tgt : pc_reg;
        req_n   = br_taken ? br_tgt : pc_reg;
        state_n = WAIT;
      end
      WAIT: begin
        if (br_taken) begin
          pc_n = br_tgt;
          // Without a response the address must stay put; the late answer is killed.
          if (imem_valid) begin
            req_n  = br_tgt;
            kill_n = 1'b0;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_valid) begin
          if (kill) begin
            kill_n = 1'b0;
            req_n  = pc_reg;
          end else begin
            fetch_hit = 1'b1;
            pc_n      = req_inc;
            if (stall) begin
              hold_instr_n = imem_rdata;
              hold_pc_n    = req_inc;
              state_n      = HOLD;
            end else begin
              lat_load = 1'b1;
              req_n    = req_inc;
            end
          end
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_n    = br_tgt;
          req_n   = br_tgt;
          state_n = WAIT;
        end else if (!stall) begin
          lat_load  = 1'b1;
          lat_instr = hold_instr;
          lat_pc    = hold_pc;
          req_n     = hold_pc;
          state_n   = WAIT;
        end
      end
      default: state_n = ISSUE;
    endcase
  end

  // Decode consumes every unstalled cycle, so an empty unstalled cycle is a bubble.
  assign lat_flush = br_taken || (!stall && !lat_load);

  fetch_latch #(.NOP_INSTR(NOP_INSTR)) u_latch (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (lat_flush),
    .load            (lat_load),
    .load_instr      (lat_instr),
    .load_pc         (lat_pc),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_hit)          fetch_count <= fetch_count + 32'd1;
      if (stall && valid_out) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
